// File: rtl/rx_param_if.sv
// Receiver-to-consumer word handshake: rx_po plus status, held until rx_data_ack.
// The receiver drives the master side; the link-layer consumer sits on the slave side.
interface rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_po;
  logic                 rx_busy;
  logic                 rx_ready;
  logic                 rx_error;
  logic                 rx_parity_err;
  logic                 rx_overrun;
  logic                 rx_data_ack;

  modport master (
    output rx_po,
    output rx_busy,
    output rx_ready,
    output rx_error,
    output rx_parity_err,
    output rx_overrun,
    input  rx_data_ack
  );

  modport slave (
    input  rx_po,
    input  rx_busy,
    input  rx_ready,
    input  rx_error,
    input  rx_parity_err,
    input  rx_overrun,
    output rx_data_ack
  );
endinterface

// File: rtl/rx_param.sv
// Oversampled async serial receiver (MSB first); word held until acked, rx_ready 3 clk after last stop mid-bit.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote around each sample point, decision one clk later.
module rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_si,
  rx_param_if.master rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_COMMIT,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 xor_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic [DATA_BITS-1:0] po_q;
  logic                 busy_q;
  logic                 ready_q;
  logic                 error_q;
  logic                 parerr_q;
  logic                 ovr_q;

  logic                 start_det;
  logic                 sampling;
  logic                 strobe;
  logic                 smp_vld;
  logic                 smp_bit;
  logic                 par_mismatch;
  logic                 commit_ok;
  logic [DATA_BITS-1:0] shift_d;

  assign start_det    = prev_q & ~sync2_q;
  assign sampling     = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
  assign strobe       = sampling && (cnt_q == '0);
  assign shift_d      = {shift_q[DATA_BITS-2:0], smp_bit};
  assign par_mismatch = (PARITY_MODE == 2) ? ~(xor_q ^ smp_bit) : (xor_q ^ smp_bit);
  assign commit_ok    = ~ready_q | rx.rx_data_ack;

`ifdef RX_MAJORITY_VOTE_EN
  logic vote1_q;
  logic vote0_q;
  logic pend_q;

  // Third vote is the live synchronised line in the cycle after the strobe.
  assign smp_vld = pend_q;
  assign smp_bit = (vote1_q & vote0_q) | (vote1_q & sync2_q) | (vote0_q & sync2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote1_q <= 1'b1;
      vote0_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      if (sampling && (cnt_q == CW'(1))) vote1_q <= sync2_q;
      if (strobe) vote0_q <= sync2_q;
      pend_q <= strobe;
    end
  end
`else
  assign smp_vld = strobe;
  assign smp_bit = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      xor_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      po_q       <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      parerr_q   <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q <= rx_si;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;

      // Free-running bit timer while a frame is in flight; the vote path reuses it.
      if (sampling) cnt_q <= (cnt_q == '0) ? CNT_FULL : cnt_q - CW'(1);

      if (rx.rx_data_ack && ready_q) begin
        ready_q  <= 1'b0;
        error_q  <= 1'b0;
        parerr_q <= 1'b0;
        ovr_q    <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_det) begin
            state_q <= S_START;
            cnt_q   <= CNT_HALF;
            busy_q  <= 1'b1;
            xor_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
          end
        end
        S_START: begin
          if (smp_vld) begin
            if (smp_bit) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              idx_q   <= IDX_TOP;
            end
          end
        end
        S_DATA: begin
          if (smp_vld) begin
            shift_q <= shift_d;
            xor_q   <= xor_q ^ smp_bit;
            if (idx_q == '0) begin
              state_q    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              stop_idx_q <= 1'b0;
            end else begin
              idx_q <= idx_q - IW'(1);
            end
          end
        end
        S_PARITY: begin
          if (smp_vld) begin
            perr_q  <= par_mismatch;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (smp_vld) begin
            if (!smp_bit) ferr_q <= 1'b1;
            if (stop_idx_q == 1'(STOP_BITS - 1)) state_q <= S_COMMIT;
            else stop_idx_q <= 1'b1;
          end
        end
        S_COMMIT: begin
          busy_q <= 1'b0;
          // A commit overrides a coincident ack; a held word makes the new frame an overrun.
          if (commit_ok) begin
            po_q     <= shift_q;
            ready_q  <= 1'b1;
            error_q  <= ferr_q;
            parerr_q <= perr_q;
            ovr_q    <= 1'b0;
          end else begin
            ovr_q <= 1'b1;
          end
          if (ferr_q) begin
            state_q <= S_WAIT_HIGH;
            cnt_q   <= CNT_FULL;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_HIGH: begin
          // Break rejection: need a full bit time of continuous high before re-arming.
          if (!sync2_q) cnt_q <= CNT_FULL;
          else if (cnt_q == '0) state_q <= S_IDLE;
          else cnt_q <= cnt_q - CW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx.rx_po         = po_q;
  assign rx.rx_busy       = busy_q;
  assign rx.rx_ready      = ready_q;
  assign rx.rx_error      = error_q;
  assign rx.rx_parity_err = parerr_q;
  assign rx.rx_overrun    = ovr_q;

endmodule

// File: tb/tb_rx_param.sv
// Bench for rx_param: default instance (8N1) and a 7-bit even-parity, two-stop instance,
// directed frames from the test plan plus random frames checked against an event-level model.
module tb_rx_param;

  localparam int OS = 8;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int MV_LAT = 1;
`else
  localparam int MV_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic line;
  logic sel;
  logic ack;
  logic rx_si_a;
  logic rx_si_b;
  logic obs_busy;
  int   compares = 0;
  int   fails    = 0;

  logic [8:0] m_po   [2];
  logic       m_rdy  [2];
  logic       m_err  [2];
  logic       m_perr [2];
  logic       m_ovr  [2];

  always #5 clk = ~clk;

  rx_param_if #(.DATA_BITS(8)) ifa ();
  rx_param_if #(.DATA_BITS(7)) ifb ();

  assign rx_si_a         = sel ? 1'b1 : line;
  assign rx_si_b         = sel ? line : 1'b1;
  assign ifa.rx_data_ack = ack & ~sel;
  assign ifb.rx_data_ack = ack & sel;
  assign obs_busy        = sel ? ifb.rx_busy : ifa.rx_busy;

  rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_si(rx_si_a), .rx(ifa.master)
  );

  rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_si(rx_si_b), .rx(ifb.master)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input string tag);
    logic [8:0] po;
    logic       rdy, bsy, er, pe, ov;
    if (d == 0) begin
      po = 9'(ifa.rx_po); rdy = ifa.rx_ready; bsy = ifa.rx_busy;
      er = ifa.rx_error;  pe = ifa.rx_parity_err; ov = ifa.rx_overrun;
    end else begin
      po = 9'(ifb.rx_po); rdy = ifb.rx_ready; bsy = ifb.rx_busy;
      er = ifb.rx_error;  pe = ifb.rx_parity_err; ov = ifb.rx_overrun;
    end
    chk({tag, "/po"},    po,       m_po[d]);
    chk({tag, "/ready"}, 9'(rdy),  9'(m_rdy[d]));
    chk({tag, "/error"}, 9'(er),   9'(m_err[d]));
    chk({tag, "/perr"},  9'(pe),   9'(m_perr[d]));
    chk({tag, "/ovr"},   9'(ov),   9'(m_ovr[d]));
    chk({tag, "/busy"},  9'(bsy),  9'd0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_po[d] = '0; m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_perr[d] = 1'b0; m_ovr[d] = 1'b0;
    end
  endtask

  task automatic model_commit(input int d, input logic [8:0] data, input bit ferr,
                              input bit perr, input bit ack_at_commit);
    if (!m_rdy[d] || ack_at_commit) begin
      m_po[d] = data; m_rdy[d] = 1'b1; m_err[d] = ferr; m_perr[d] = perr; m_ovr[d] = 1'b0;
    end else begin
      m_ovr[d] = 1'b1;
    end
  endtask

  task automatic model_ack(input int d);
    if (m_rdy[d]) begin
      m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_perr[d] = 1'b0; m_ovr[d] = 1'b0;
    end
  endtask

  function automatic bit even_par_err(input logic [8:0] data, input bit par);
    return ((($countones(data[6:0]) + int'(par)) % 2) != 0);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic gap(input int n);
    line = 1'b1;
    idle(n);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic watch(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (obs_busy) seen = 1'b1;
    end
  endtask

  // Start bit, data MSB first, optional parity, stop bits; line left at the last bit value.
  task automatic send_frame(input int nb, input logic [8:0] data, input bit has_par,
                            input bit par, input int nstop, input logic [1:0] stops,
                            input bit ack_last);
    bit q[$];
    q.push_back(1'b0);
    for (int i = nb - 1; i >= 0; i--) q.push_back(data[i]);
    if (has_par) q.push_back(par);
    for (int s = 0; s < nstop; s++) q.push_back(stops[s]);
    @(posedge clk); #1;
    for (int k = 0; k < q.size(); k++) begin
      line = q[k];
      if ((k == q.size() - 1) && ack_last) begin
        idle(OS - 1);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
      end else begin
        idle(OS);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [8:0] d;
    bit st, al, pb, s0, s1;

    rst_n = 1'b1; line = 1'b1; sel = 1'b0; ack = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #10;
    check_dut(0, "rst_a");
    check_dut(1, "rst_b");
    @(negedge clk) rst_n = 1'b1;
    gap(4);

    // 0xA5, rx_ready right at the commit edge
    send_frame(8, 9'hA5, 0, 0, 1, 2'b11, 0);
    idle(MV_LAT);
    model_commit(0, 9'hA5, 0, 0, 0);
    check_dut(0, "a5");
    gap(2);
    pulse_ack(); model_ack(0);
    check_dut(0, "a5_ack");
    pulse_ack(); model_ack(0);
    check_dut(0, "ack_idle");

    // 0x3C with bad stop bit, then a break that must not re-arm early
    send_frame(8, 9'h3C, 0, 0, 1, 2'b00, 0);
    idle(MV_LAT);
    model_commit(0, 9'h3C, 1, 0, 0);
    check_dut(0, "3c_ferr");
    idle(20);
    line = 1'b1; idle(4);
    line = 1'b0;
    watch(12, seen);
    chk("break_no_start", 9'(seen), 9'd0);
    gap(2 * OS);
    pulse_ack(); model_ack(0);
    send_frame(8, 9'h5A, 0, 0, 1, 2'b11, 0);
    gap(2 * OS);
    model_commit(0, 9'h5A, 0, 0, 0);
    check_dut(0, "after_break");
    pulse_ack(); model_ack(0);

    // 3-clk glitch: false start
    line = 1'b0; idle(3); line = 1'b1;
    watch(14, seen);
    chk("glitch_busy_seen", 9'(seen), 9'd1);
    check_dut(0, "glitch");

    // Overrun, then ack coinciding with commit
    send_frame(8, 9'h11, 0, 0, 1, 2'b11, 0); gap(2 * OS); model_commit(0, 9'h11, 0, 0, 0);
    send_frame(8, 9'h22, 0, 0, 1, 2'b11, 0); gap(2 * OS); model_commit(0, 9'h22, 0, 0, 0);
    check_dut(0, "overrun");
    pulse_ack(); model_ack(0);
    check_dut(0, "overrun_ack");
    send_frame(8, 9'h11, 0, 0, 1, 2'b11, 0); gap(2 * OS); model_commit(0, 9'h11, 0, 0, 0);
    send_frame(8, 9'h22, 0, 0, 1, 2'b11, 1);
    idle(MV_LAT);
    model_commit(0, 9'h22, 0, 0, 1);
    check_dut(0, "ack_on_commit");
    gap(2 * OS);

    // Parity instance: 7 data bits, even parity, two stop bits
    sel = 1'b1;
    send_frame(7, 9'h55, 1, 1, 2, 2'b11, 0); gap(2 * OS);
    model_commit(1, 9'h55, 0, even_par_err(9'h55, 1), 0);
    check_dut(1, "par_bad");
    pulse_ack(); model_ack(1);
    send_frame(7, 9'h55, 1, 0, 2, 2'b11, 0); gap(2 * OS);
    model_commit(1, 9'h55, 0, even_par_err(9'h55, 0), 0);
    check_dut(1, "par_good");
    pulse_ack(); model_ack(1);

    for (int i = 0; i < 12; i++) begin
      d  = 9'($urandom_range(127, 0));
      pb = 1'($urandom_range(1, 0));
      s0 = ($urandom_range(3, 0) != 0);
      s1 = ($urandom_range(3, 0) != 0);
      al = ($urandom_range(3, 0) == 0);
      send_frame(7, d, 1, pb, 2, {s1, s0}, al);
      model_commit(1, d, !(s0 && s1), even_par_err(d, pb), al);
      gap(2 * OS);
      check_dut(1, "rnd_b");
      if ($urandom_range(1, 0) == 1) begin
        pulse_ack(); model_ack(1);
        check_dut(1, "rnd_b_ack");
      end
    end
    gap(2 * OS);

    sel = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d  = 9'($urandom_range(255, 0));
      st = ($urandom_range(5, 0) != 0);
      al = ($urandom_range(3, 0) == 0);
      send_frame(8, d, 0, 0, 1, {1'b1, st}, al);
      model_commit(0, d, !st, 0, al);
      gap(2 * OS);
      check_dut(0, "rnd_a");
      if ($urandom_range(1, 0) == 1) begin
        pulse_ack(); model_ack(0);
        check_dut(0, "rnd_a_ack");
      end
    end

    // Reset in the middle of a 0xFF frame while a word is held
    send_frame(8, 9'h77, 0, 0, 1, 2'b11, 0); gap(2 * OS);
    model_commit(0, 9'h77, 0, 0, 0);
    check_dut(0, "pre_rst");
    line = 1'b0; idle(OS);
    line = 1'b1; idle(3 * OS);
    chk("busy_mid_frame", 9'(ifa.rx_busy), 9'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_dut(0, "mid_rst_a");
    check_dut(1, "mid_rst_b");
    @(negedge clk) rst_n = 1'b1;
    gap(2 * OS);
    send_frame(8, 9'h81, 0, 0, 1, 2'b11, 0);
    idle(MV_LAT);
    model_commit(0, 9'h81, 0, 0, 0);
    check_dut(0, "post_rst_81");
    gap(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
